// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types, scan-code constants and helpers for the PS/2 keymap controller
package ps2_pkg;

    typedef enum logic [2:0] {
        DIR_UP    = 3'd0,
        DIR_DOWN  = 3'd1,
        DIR_LEFT  = 3'd2,
        DIR_RIGHT = 3'd3,
        DIR_STOP  = 3'd4
    } dir_t;

    localparam int K_UP    = 0;
    localparam int K_DOWN  = 1;
    localparam int K_LEFT  = 2;
    localparam int K_RIGHT = 3;
    localparam int K_BOMB  = 4;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_PAUSE  = 8'hE1;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_BAT    = 8'hAA;
    localparam logic [7:0] SC_ECHO   = 8'hEE;
    localparam logic [7:0] SC_RESEND = 8'hFE;

    typedef struct packed {
        logic       valid;
        logic       brk;
        logic       ext;
        logic [7:0] code;
    } ps2_evt_t;

    // Bytes the keyboard sends that never form part of a key event
    function automatic logic is_ignored(input logic [7:0] b);
        return b == SC_PAUSE || b == SC_ACK || b == SC_BAT || b == SC_ECHO || b == SC_RESEND;
    endfunction

    // Highest-priority held direction: UP > DOWN > LEFT > RIGHT, else STOP
    function automatic dir_t prio_dir(input logic [3:0] m);
        return m[K_UP] ? DIR_UP : m[K_DOWN] ? DIR_DOWN : m[K_LEFT] ? DIR_LEFT : m[K_RIGHT] ? DIR_RIGHT : DIR_STOP;
    endfunction

endpackage

// File: rtl/ps2_keymap_ctrl_if.sv
// ps2_keymap_ctrl_if: byte input and per-player game outputs of the keymap controller
interface ps2_keymap_ctrl_if #(parameter int N_PLAYERS = 2);
    logic [7:0]             rx_data;
    logic                   rx_done_tick;
    logic                   clear;
    logic [3*N_PLAYERS-1:0] direction;
    logic [N_PLAYERS-1:0]   dir_valid;
    logic [N_PLAYERS-1:0]   bomb;
    logic [5*N_PLAYERS-1:0] held;
    logic                   rx_success;
    logic [15:0]            disp;

    modport master (
        output rx_data, rx_done_tick, clear,
        input  direction, dir_valid, bomb, held, rx_success, disp
    );

    modport slave (
        input  rx_data, rx_done_tick, clear,
        output direction, dir_valid, bomb, held, rx_success, disp
    );
endinterface

// File: rtl/ps2_scan_decoder.sv
// ps2_scan_decoder: turns the PS/2 byte stream into make/break events with an inter-byte timeout
module ps2_scan_decoder
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_done_tick,
    input  logic       clear,
    output ps2_evt_t   evt
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Next-state, timeout counter and the event completed by the current byte
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        evt     = '0;
        if (clear) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (rx_done_tick) begin
            cnt_d = '0;
            case (state_q)
                S_IDLE: begin
                    if (rx_data == SC_EXT) state_d = S_EXT;
                    else if (rx_data == SC_BRK) state_d = S_BRK;
                    else if (!is_ignored(rx_data)) evt = '{valid: 1'b1, brk: 1'b0, ext: 1'b0, code: rx_data};
                end
                S_EXT: begin
                    if (rx_data == SC_BRK) state_d = S_EXT_BRK;
                    else if (rx_data != SC_EXT) begin
                        evt     = '{valid: 1'b1, brk: 1'b0, ext: 1'b1, code: rx_data};
                        state_d = S_IDLE;
                    end
                end
                S_BRK: begin
                    if (rx_data != SC_BRK) begin
                        evt     = '{valid: 1'b1, brk: 1'b1, ext: 1'b0, code: rx_data};
                        state_d = S_IDLE;
                    end
                end
                S_EXT_BRK: begin
                    if (rx_data != SC_BRK && rx_data != SC_EXT) begin
                        evt     = '{valid: 1'b1, brk: 1'b1, ext: 1'b1, code: rx_data};
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE) begin
            if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Decoder state and timeout counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: rtl/ps2_keymap_ctrl.sv
// ps2_keymap_ctrl: maps decoded PS/2 events to per-player held keys, direction and bomb strobes
module ps2_keymap_ctrl
    import ps2_pkg::*;
#(
    parameter int                     N_PLAYERS   = 2,
    parameter logic [N_PLAYERS*45-1:0] KEYMAP     = {
        9'h029, 9'h023, 9'h01C, 9'h01B, 9'h01D,
        9'h05A, 9'h174, 9'h16B, 9'h172, 9'h175
    },
    parameter int                     TIMEOUT_CYC = 100000
) (
    input logic              clk,
    input logic              rst_n,
    ps2_keymap_ctrl_if.slave bus
);
    ps2_evt_t             evt;
    logic [N_PLAYERS-1:0] chg;
    logic                 rx_success_q, rx_success_d;
    logic [15:0]          disp_q, disp_d;

    ps2_scan_decoder #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_dec (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data      (bus.rx_data),
        .rx_done_tick (bus.rx_done_tick),
        .clear        (bus.clear),
        .evt          (evt)
    );

    for (genvar p = 0; p < N_PLAYERS; p++) begin : g_pl
        logic [4:0] match, set, clr, held_q, held_d;
        dir_t       dir_q, dir_d;
        logic       dv_q, dv_d, bomb_q, bomb_d;

        // Keymap compare and held/direction update for this player
        always_comb begin
            for (int k = 0; k < 5; k++) match[k] = evt.valid && ({evt.ext, evt.code} == KEYMAP[(p*5+k)*9 +: 9]);
            set    = evt.brk ? 5'b0 : match & ~held_q;
            clr    = evt.brk ? match & held_q : 5'b0;
            held_d = bus.clear ? 5'b0 : (held_q | set) & ~clr;
            dir_d  = dir_q;
            if (bus.clear) dir_d = DIR_STOP;
            else if (|set[3:0]) dir_d = prio_dir(set[3:0]);
            else if (dir_q != DIR_STOP && clr[dir_q[1:0]]) dir_d = prio_dir(held_d[3:0]);
            dv_d   = !bus.clear && dir_d != dir_q;
            bomb_d = set[K_BOMB];
        end

        // Per-player registered outputs
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                held_q <= '0;
                dir_q  <= DIR_STOP;
                dv_q   <= 1'b0;
                bomb_q <= 1'b0;
            end else begin
                held_q <= held_d;
                dir_q  <= dir_d;
                dv_q   <= dv_d;
                bomb_q <= bomb_d;
            end
        end

        assign chg[p]                = |set || |clr;
        assign bus.direction[3*p +: 3] = dir_q;
        assign bus.held[5*p +: 5]      = held_q;
        assign bus.dir_valid[p]        = dv_q;
        assign bus.bomb[p]             = bomb_q;
    end

    // Success strobe for any state-changing mapped event; debug shift of raw nibbles
    always_comb begin
        rx_success_d = |chg;
        disp_d       = bus.rx_done_tick ? {disp_q[11:0], bus.rx_data[3:0]} : disp_q;
    end

    // Shared registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_success_q <= 1'b0;
            disp_q       <= '0;
        end else begin
            rx_success_q <= rx_success_d;
            disp_q       <= disp_d;
        end
    end

    assign bus.rx_success = rx_success_q;
    assign bus.disp       = disp_q;
endmodule

// File: tb/tb_ps2_keymap_ctrl.sv
// tb_ps2_keymap_ctrl: directed and random byte streams checked against a key-state reference model
module tb_ps2_keymap_ctrl;
    localparam int NP = 2;
    localparam int T  = 40;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ps2_keymap_ctrl_if #(.N_PLAYERS(NP)) bus();

    ps2_keymap_ctrl #(.N_PLAYERS(NP), .TIMEOUT_CYC(T)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int         km [NP][5] = '{'{'h175, 'h172, 'h16B, 'h174, 'h05A}, '{'h01D, 'h01B, 'h01C, 'h023, 'h029}};
    bit         hm [NP][5];
    int         dm [NP];
    bit         pend_ext, pend_brk;
    int         cyc, last_tick;
    logic [15:0] md;
    logic [NP-1:0] mdv, mb;
    bit         mrx;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        hm = '{default: 0};
        dm = '{default: 4};
        pend_ext = 0;
        pend_brk = 0;
        md = '0;
        mdv = '0;
        mb = '0;
        mrx = 0;
    endtask

    task automatic apply(input bit brk, input logic [8:0] c);
        for (int p = 0; p < NP; p++)
            for (int k = 0; k < 5; k++)
                if (km[p][k] == int'(c)) begin
                    if (!brk && !hm[p][k]) begin
                        hm[p][k] = 1;
                        mrx = 1;
                        if (k == 4) mb[p] = 1;
                        else if (dm[p] != k) begin
                            dm[p] = k;
                            mdv[p] = 1;
                        end
                    end else if (brk && hm[p][k]) begin
                        hm[p][k] = 0;
                        mrx = 1;
                        if (k < 4 && dm[p] == k) begin
                            int nd;
                            nd = 4;
                            for (int j = 3; j >= 0; j--) if (hm[p][j]) nd = j;
                            dm[p] = nd;
                            mdv[p] = 1;
                        end
                    end
                end
    endtask

    task automatic model_step(input bit tk, input logic [7:0] b, input bit cl);
        mdv = '0;
        mb = '0;
        mrx = 0;
        if (tk) md = {md[11:0], b[3:0]};
        if (cl) begin
            hm = '{default: 0};
            dm = '{default: 4};
            pend_ext = 0;
            pend_brk = 0;
        end else if (tk) begin
            if ((pend_ext || pend_brk) && cyc - last_tick > T) begin
                pend_ext = 0;
                pend_brk = 0;
            end
            if (!pend_ext && !pend_brk) begin
                if (b == 8'hE0) pend_ext = 1;
                else if (b == 8'hF0) pend_brk = 1;
                else if (!(b inside {8'hE1, 8'hFA, 8'hAA, 8'hEE, 8'hFE})) apply(0, {1'b0, b});
            end else if (!pend_brk) begin
                if (b == 8'hF0) pend_brk = 1;
                else if (b != 8'hE0) begin
                    apply(0, {1'b1, b});
                    pend_ext = 0;
                end
            end else if (!pend_ext) begin
                if (b != 8'hF0) begin
                    apply(1, {1'b0, b});
                    pend_brk = 0;
                end
            end else if (b != 8'hF0 && b != 8'hE0) begin
                apply(1, {1'b1, b});
                pend_ext = 0;
                pend_brk = 0;
            end
        end
        if (tk) last_tick = cyc;
    endtask

    task automatic check_all();
        logic [31:0] ed, eh;
        ed = '0;
        eh = '0;
        for (int p = 0; p < NP; p++) begin
            ed[3*p +: 3] = 3'(dm[p]);
            for (int k = 0; k < 5; k++) eh[5*p+k] = hm[p][k];
        end
        check_val("direction", 32'(bus.direction), ed);
        check_val("held", 32'(bus.held), eh);
        check_val("dir_valid", 32'(bus.dir_valid), 32'(mdv));
        check_val("bomb", 32'(bus.bomb), 32'(mb));
        check_val("rx_success", 32'(bus.rx_success), 32'(mrx));
        check_val("disp", 32'(bus.disp), 32'(md));
    endtask

    task automatic cycle(input bit tk, input logic [7:0] b, input bit cl);
        @(negedge clk);
        bus.rx_done_tick = tk;
        bus.rx_data = b;
        bus.clear = cl;
        cyc++;
        model_step(tk, b, cl);
        @(posedge clk);
        #1 check_all();
    endtask

    task automatic send(input logic [7:0] b);
        cycle(1, b, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 8'h00, 0);
    endtask

    initial begin
        bus.rx_data = '0;
        bus.rx_done_tick = 0;
        bus.clear = 0;
        cyc = 0;
        last_tick = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_all();
        @(negedge clk) rst_n = 1;

        send(8'hE0); send(8'h75);
        check_val("tp_up_dir", 32'(bus.direction[2:0]), 32'd0);
        check_val("tp_up_dv", 32'(bus.dir_valid[0]), 32'd1);
        idle(1);
        send(8'hE0); send(8'hF0); send(8'h75);
        check_val("tp_stop_dir", 32'(bus.direction[2:0]), 32'd4);
        idle(1);

        send(8'h1D); send(8'h1C); send(8'hF0); send(8'h1C);
        check_val("tp_p1_up", 32'(bus.direction[5:3]), 32'd0);
        idle(1);

        send(8'h5A); send(8'h5A); send(8'h5A); send(8'hF0); send(8'h5A);
        idle(1);

        send(8'h75);
        check_val("bare75_rxs", 32'(bus.rx_success), 32'd0);
        check_val("bare75_disp", 32'(bus.disp[3:0]), 32'd5);

        send(8'hF0); idle(T + 2); send(8'h1B);
        check_val("timeout_make", 32'(bus.direction[5:3]), 32'd1);
        send(8'hF0); idle(T - 1); send(8'h1B);
        check_val("edge_break", 32'(bus.held[6]), 32'd0);
        send(8'hF0); send(8'h1D); idle(1);

        send(8'h23);
        cycle(1, 8'hF0, 1);
        check_val("clear_dir", 32'(bus.direction[5:3]), 32'd4);
        send(8'h23);
        check_val("after_clear", 32'(bus.direction[5:3]), 32'd3);
        idle(1);

        send(8'hE0);
        @(negedge clk);
        bus.rx_done_tick = 0;
        rst_n = 0;
        #1 model_reset();
        check_all();
        @(negedge clk) rst_n = 1;
        send(8'h75);
        check_val("rst_discard", 32'(bus.direction[2:0]), 32'd4);

        for (int i = 0; i < 600; i++) begin
            int r;
            logic [7:0] b;
            r = $urandom_range(0, 99);
            b = r < 20 ? 8'hE0 : r < 40 ? 8'hF0 : r < 85 ? 8'(km[$urandom_range(0, NP-1)][$urandom_range(0, 4)]) :
                r < 92 ? 8'hFA : 8'($urandom);
            r = $urandom_range(0, 99);
            if (r < 3) cycle(1, b, 1);
            else if (r < 5) cycle(0, 8'h00, 1);
            else cycle(1, b, 0);
            r = $urandom_range(0, 99);
            if (r < 4) idle(T - 1 + $urandom_range(0, 2));
            else idle($urandom_range(0, 2));
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
